// File: rtl/countdown_timer.sv
// Countdown timer: BCD mm:ss display counted down from a loaded preset,
// with run/pause control and an expiry level plus one-cycle strobe.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 10000
) (
    input  logic       clk_10000Hz,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] preset_min,
    input  logic [5:0] preset_sec,
    input  logic       start_stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [13:0] sub_cnt,
    output logic       running,
    output logic       expired,
    output logic       expired_pulse
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam logic [13:0] LAST_TICK = 14'(TICKS_PER_SEC - 1);

    logic [1:0] state;

    logic [6:0] min_c;
    logic [5:0] sec_c;
    logic [3:0] ld_mt, ld_mo, ld_st, ld_so;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic       is_zero, at_one;

    // Preset clamp and binary-to-BCD split
    always_comb begin
        min_c = (preset_min > 7'd99) ? 7'd99 : preset_min;
        sec_c = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
        ld_mt = 4'(min_c / 7'd10);
        ld_mo = 4'(min_c % 7'd10);
        ld_st = 4'(sec_c / 6'd10);
        ld_so = 4'(sec_c % 6'd10);
    end

    // One-second BCD decrement with borrow chain
    always_comb begin
        dec_mt = min_tens;
        dec_mo = min_ones;
        dec_st = sec_tens;
        dec_so = sec_ones;
        if (sec_ones != 4'd0) begin
            dec_so = sec_ones - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_st = sec_tens - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (min_ones != 4'd0) begin
                    dec_mo = min_ones - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    if (min_tens != 4'd0)
                        dec_mt = min_tens - 4'd1;
                end
            end
        end
    end

    assign is_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
    assign at_one  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

    always_ff @(posedge clk_10000Hz or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            min_tens      <= 4'd0;
            min_ones      <= 4'd0;
            sec_tens      <= 4'd0;
            sec_ones      <= 4'd0;
            sub_cnt       <= 14'd0;
            expired_pulse <= 1'b0;
        end else if (load) begin
            state         <= S_IDLE;
            min_tens      <= ld_mt;
            min_ones      <= ld_mo;
            sec_tens      <= ld_st;
            sec_ones      <= ld_so;
            sub_cnt       <= 14'd0;
            expired_pulse <= 1'b0;
        end else begin
            expired_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_stop && !is_zero) begin
                        state   <= S_RUN;
                        sub_cnt <= 14'd0;
                    end
                end
                S_RUN: begin
                    // A pause request beats a coincident wrap
                    if (start_stop) begin
                        state <= S_PAUSE;
                    end else if (sub_cnt == LAST_TICK) begin
                        sub_cnt  <= 14'd0;
                        min_tens <= dec_mt;
                        min_ones <= dec_mo;
                        sec_tens <= dec_st;
                        sec_ones <= dec_so;
                        if (at_one) begin
                            state         <= S_EXPIRED;
                            expired_pulse <= 1'b1;
                        end
                    end else begin
                        sub_cnt <= sub_cnt + 14'd1;
                    end
                end
                S_PAUSE: begin
                    if (start_stop)
                        state <= S_RUN;
                end
                default: ;
            endcase
        end
    end

    assign running = (state == S_RUN);
    assign expired = (state == S_EXPIRED);

endmodule
